// File: rtl/mcs4_ram_initiator_pkg.sv
// Shared MCS-4 bus types plus the RAM/IO initiator command and state definitions.
package mcs4_ram_initiator_pkg;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef enum logic [3:0] {
    WRM = 4'h0, WMP, WRR, WPM, WR0, WR1, WR2, WR3,
    SBM, RDM, RDR, ADM, RD0, RD1, RD2, RD3
  } ioram_opa_t;

  localparam char_t Opr_src = 4'h2;
  localparam char_t Opr_io  = 4'hE;

  typedef struct packed {
    ioram_opa_t  opa;
    logic [1:0]  bank;
    byte_t       addr;
    char_t       wdata;
  } ioram_cmd_t;

  typedef enum logic [1:0] {IDLE, SRC, IO} init_state_t;

  // The upper half of the I/O opcode space is the read group.
  function automatic logic is_ioram_read(ioram_opa_t opa);
    return opa[3];
  endfunction

endpackage

// File: rtl/mcs4_cycle_timer.sv
// Free-running A1..X3 instruction-cycle phase counter; sync marks X3.
module mcs4_cycle_timer
  import mcs4_ram_initiator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output instr_cyc_t phase,
  output instr_cyc_t phase_nxt,
  output logic       sync
);

  always_comb begin
    phase_nxt = (phase == X3) ? A1 : instr_cyc_t'(phase + 3'd1);
  end

  // Parking in X3 keeps sync high through reset so bus agents resync on release.
  always_ff @(posedge clk) begin
    if (rst) phase <= X3;
    else     phase <= phase_nxt;
  end

  assign sync = (phase == X3);

endmodule

// File: rtl/mcs4_ram_initiator.sv
// CPU-side initiator for the 4002 RAM bus: turns host commands into SRC + I/O instruction cycles.
module mcs4_ram_initiator
  import mcs4_ram_initiator_pkg::*;
#(
  parameter int NUM_BANKS = 1,
  parameter int SRC_CACHE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sync,
  output logic [NUM_BANKS-1:0] cm_ram,
  output logic [3:0]           dbus_out,
  input  logic [3:0]           dbus_in,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_opa,
  input  logic [1:0]           cmd_bank,
  input  logic [7:0]           cmd_addr,
  input  logic [3:0]           cmd_wdata,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_data
);

  // Handshake: a command transfers on a clock where cmd_valid && cmd_ready; cmd_ready
  // is only ever high in X3 of an IDLE or IO cycle, and cmd_* need only be stable then.

  instr_cyc_t  phase, phase_nxt;
  init_state_t state, state_nxt;
  ioram_cmd_t  cmd, cmd_nxt;
  logic        addr_vld;
  logic [1:0]  last_bank;
  byte_t       last_addr;
  logic        accept, src_needed, cur_bank_ok;
  logic [NUM_BANKS-1:0] bank_sel, cm_nxt;
  char_t       dbus_nxt;

  mcs4_cycle_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .phase_nxt (phase_nxt),
    .sync      (sync)
  );

  always_comb begin
    accept      = cmd_valid && cmd_ready;
    src_needed  = (SRC_CACHE == 0) || !addr_vld || (cmd_bank != last_bank) || (cmd_addr != last_addr);
    cur_bank_ok = int'(cmd.bank) < NUM_BANKS;

    cmd_nxt = cmd;
    if (accept) cmd_nxt = '{opa: ioram_opa_t'(cmd_opa), bank: cmd_bank, addr: cmd_addr, wdata: cmd_wdata};

    state_nxt = state;
    if (phase == X3) begin
      case (state)
        SRC:     state_nxt = IO;
        default: state_nxt = accept ? (src_needed ? SRC : IO) : IDLE;
      endcase
    end

    // Out-of-range banks match no bit, so the cycles run with cm_ram silent.
    bank_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(cmd_nxt.bank) == b) bank_sel[b] = 1'b1;
    end

    // Bus outputs are registered, so they are computed for the phase about to start.
    cm_nxt   = '0;
    dbus_nxt = '0;
    case (state_nxt)
      SRC: begin
        case (phase_nxt)
          M1: dbus_nxt = Opr_src;
          M2: dbus_nxt = 4'h1;
          X2: begin
            cm_nxt   = bank_sel;
            dbus_nxt = cmd_nxt.addr[7:4];
          end
          X3: dbus_nxt = cmd_nxt.addr[3:0];
          default: dbus_nxt = '0;
        endcase
      end
      IO: begin
        case (phase_nxt)
          M1: dbus_nxt = Opr_io;
          M2: begin
            cm_nxt   = bank_sel;
            dbus_nxt = cmd_nxt.opa;
          end
          // cm_ram stays low in X2 so the 4002 keeps its latched address.
          X2: dbus_nxt = is_ioram_read(cmd_nxt.opa) ? 4'h0 : cmd_nxt.wdata;
          default: dbus_nxt = '0;
        endcase
      end
      default: begin
        cm_nxt   = '0;
        dbus_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      cm_ram    <= '0;
      dbus_out  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      addr_vld  <= 1'b0;
      last_bank <= '0;
      last_addr <= '0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      cm_ram    <= cm_nxt;
      dbus_out  <= dbus_nxt;
      cmd_ready <= (phase_nxt == X3) && (state_nxt != SRC);
      rsp_valid <= (state == IO) && (phase == X2);
      if ((state == IO) && (phase == X2)) begin
        rsp_data <= (is_ioram_read(cmd.opa) && cur_bank_ok) ? dbus_in : 4'h0;
      end
      if ((state == SRC) && (phase == X3)) begin
        last_addr <= cmd.addr;
        last_bank <= cmd.bank;
        addr_vld  <= cur_bank_ok;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_ram_initiator.sv
// Bench for mcs4_ram_initiator: two behavioural 4002 chips on bank 0 plus a no-cache instance.
module tb_mcs4_ram_initiator;
  import mcs4_ram_initiator_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       sync, cmd_ready, rsp_valid, cmd_valid;
  logic [0:0] cm_ram;
  logic [3:0] dbus_out, dbus_in, rsp_data, cmd_opa, cmd_wdata;
  logic [1:0] cmd_bank;
  logic [7:0] cmd_addr;

  logic       sync_nc, cmd_ready_nc, rsp_valid_nc, cmd_valid_nc;
  logic [0:0] cm_ram_nc;
  logic [3:0] dbus_out_nc, rsp_data_nc;
  logic [3:0] dbus_in_nc = 4'h0;

  mcs4_ram_initiator #(.NUM_BANKS(1), .SRC_CACHE(1)) u_dut (
    .clk(clk), .rst(rst), .sync(sync), .cm_ram(cm_ram), .dbus_out(dbus_out), .dbus_in(dbus_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opa(cmd_opa), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  mcs4_ram_initiator #(.NUM_BANKS(1), .SRC_CACHE(0)) u_dut_nc (
    .clk(clk), .rst(rst), .sync(sync_nc), .cm_ram(cm_ram_nc), .dbus_out(dbus_out_nc), .dbus_in(dbus_in_nc),
    .cmd_valid(cmd_valid_nc), .cmd_ready(cmd_ready_nc), .cmd_opa(cmd_opa), .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid_nc), .rsp_data(rsp_data_nc)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  string test_name = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", test_name, tag, got, exp);
    end
  endtask

  // ---------------- 4002 pair model (chip ids 0 and 1, bank 0) ----------------
  instr_cyc_t m_ph = A1;
  instr_cyc_t cur;
  assign cur = sync ? X3 : m_ph;
  always @(posedge clk) m_ph <= sync ? A1 : instr_cyc_t'(m_ph + 3'd1);

  logic [3:0] mem  [2][4][16];
  logic [3:0] stat [2][4][4];
  logic [3:0] io_out [2];
  logic [1:0] sel_chip = 2'd0, sel_reg = 2'd0;
  logic [3:0] sel_char = 4'd0, io_opa = 4'd0;
  logic       src_pend = 1'b0, io_act = 1'b0;

  initial begin
    for (int c = 0; c < 2; c++) begin
      io_out[c] = 4'h0;
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 16; k++) mem[c][r][k] = 4'h0;
        for (int k = 0; k < 4; k++)  stat[c][r][k] = 4'h0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      src_pend <= 1'b0;
      io_act   <= 1'b0;
    end else begin
      if (cur == X2 && cm_ram[0]) begin
        sel_chip <= dbus_out[3:2];
        sel_reg  <= dbus_out[1:0];
        src_pend <= 1'b1;
      end
      if (cur == X3 && src_pend) begin
        sel_char <= dbus_out;
        src_pend <= 1'b0;
      end
      if (cur == M2 && cm_ram[0]) begin
        io_opa <= dbus_out;
        io_act <= 1'b1;
      end
      if (cur == X2 && io_act && !cm_ram[0] && !sel_chip[1]) begin
        case (io_opa)
          4'h0: mem[sel_chip[0]][sel_reg][sel_char] <= dbus_out;
          4'h1: io_out[sel_chip[0]] <= dbus_out;
          4'h4, 4'h5, 4'h6, 4'h7: stat[sel_chip[0]][sel_reg][io_opa[1:0]] <= dbus_out;
          default: ;
        endcase
      end
      if (cur == X3) io_act <= 1'b0;
    end
  end

  always_comb begin
    dbus_in = 4'h0;
    if (cur == X2 && io_act && !sel_chip[1]) begin
      case (io_opa)
        4'h8, 4'h9, 4'hB:        dbus_in = mem[sel_chip[0]][sel_reg][sel_char];
        4'hC, 4'hD, 4'hE, 4'hF:  dbus_in = stat[sel_chip[0]][sel_reg][io_opa[1:0]];
        default:                 dbus_in = 4'h0;
      endcase
    end
  end

  // ---------------- bus monitors ----------------
  int   src_cnt = 0, src_cnt_nc = 0, cm_cnt = 0, cm_bad = 0, rsp_nc = 0;
  logic in_io = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (cur == M1 && dbus_out == 4'h2)    src_cnt    <= src_cnt + 1;
      if (cur == M1 && dbus_out_nc == 4'h2) src_cnt_nc <= src_cnt_nc + 1;
      if (cm_ram != 1'b0) cm_cnt <= cm_cnt + 1;
      if (cur == M1) in_io <= (dbus_out == 4'hE);
      if (cur == X2 && in_io && cm_ram != 1'b0) cm_bad <= cm_bad + 1;
      if (rsp_valid_nc) rsp_nc <= rsp_nc + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];
  logic [3:0] e_data;
  int         e_lat, e_acc;

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e_data = exp_q.pop_front();
        e_lat  = lat_q.pop_front();
        e_acc  = acc_q.pop_front();
        check("rsp_data", {28'd0, rsp_data}, {28'd0, e_data});
        check("rsp_latency", cyc - e_acc, e_lat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit nc, input logic [3:0] opa, input logic [1:0] bank, input logic [7:0] addr,
                      input logic [3:0] wd, input bit expect_rsp, input logic [3:0] exp_d, input int exp_lat);
    int t = 0;
    @(negedge clk);
    while (!(nc ? cmd_ready_nc : cmd_ready) && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!(nc ? cmd_ready_nc : cmd_ready)) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_opa = opa; cmd_bank = bank; cmd_addr = addr; cmd_wdata = wd;
    if (nc) cmd_valid_nc = 1'b1;
    else    cmd_valid    = 1'b1;
    if (expect_rsp && !nc) begin
      exp_q.push_back(exp_d);
      lat_q.push_back(exp_lat);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid_nc = 1'b0;
    // Fields only matter in the accept cycle; scramble them afterwards.
    cmd_opa   = 4'($urandom_range(0, 15));
    cmd_bank  = 2'($urandom_range(0, 3));
    cmd_addr  = 8'($urandom_range(0, 255));
    cmd_wdata = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 32'd0);
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  int snap, t;

  initial begin
    cmd_valid = 1'b0; cmd_valid_nc = 1'b0;
    cmd_opa = 4'h0; cmd_bank = 2'd0; cmd_addr = 8'h00; cmd_wdata = 4'h0;

    repeat (4) @(negedge clk);
    check("sync", {31'd0, sync}, 32'd1);
    check("cm_ram", {31'd0, cm_ram}, 32'd0);
    check("dbus_out", {28'd0, dbus_out}, 32'd0);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_data", {28'd0, rsp_data}, 32'd0);
    rst = 1'b0;

    test_name = "write_read";
    send(0, WRM, 2'd0, 8'h05, 4'hA, 1, 4'h0, 16);
    send(0, RDM, 2'd0, 8'h05, 4'h0, 1, 4'hA, 8);
    drain();

    test_name = "chip_select";
    send(0, WRM, 2'd0, 8'h43, 4'h7, 1, 4'h0, 16);
    drain();
    check("chip1_char3", {28'd0, mem[1][0][3]}, 32'h7);
    check("chip0_char3", {28'd0, mem[0][0][3]}, 32'h0);
    send(0, RDM, 2'd0, 8'h03, 4'h0, 1, 4'h0, 16);
    drain();

    test_name = "status";
    send(0, WR2, 2'd0, 8'h10, 4'hC, 1, 4'h0, 16);
    send(0, RD2, 2'd0, 8'h10, 4'h0, 1, 4'hC, 8);
    drain();
    check("stat_r1_2", {28'd0, stat[0][1][2]}, 32'hC);
    check("cm_low_io_x2", cm_bad, 32'd0);

    test_name = "cache";
    snap = src_cnt;
    send(0, RDM, 2'd0, 8'h05, 4'h0, 1, 4'hA, 16);
    send(0, RDM, 2'd0, 8'h05, 4'h0, 1, 4'hA, 8);
    send(0, RDM, 2'd0, 8'h06, 4'h0, 1, 4'h0, 16);
    drain();
    check("src_count", src_cnt - snap, 32'd2);

    test_name = "no_cache";
    snap = src_cnt_nc;
    send(1, RDM, 2'd0, 8'h05, 4'h0, 0, 4'h0, 0);
    send(1, RDM, 2'd0, 8'h05, 4'h0, 0, 4'h0, 0);
    send(1, RDM, 2'd0, 8'h06, 4'h0, 0, 4'h0, 0);
    t = 0;
    while (rsp_nc < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rsp_count", rsp_nc, 32'd3);
    check("src_count", src_cnt_nc - snap, 32'd3);

    test_name = "port";
    send(0, WRM, 2'd0, 8'h05, 4'hA, 1, 4'h0, 16);
    send(0, WMP, 2'd0, 8'h05, 4'h9, 1, 4'h0, 8);
    drain();
    check("chip0_io_out", {28'd0, io_out[0]}, 32'h9);
    check("chip1_io_out", {28'd0, io_out[1]}, 32'h0);

    test_name = "bad_bank";
    snap = cm_cnt;
    send(0, RDM, 2'd3, 8'h05, 4'h0, 1, 4'h0, 16);
    drain();
    check("cm_never", cm_cnt - snap, 32'd0);
    send(0, RDM, 2'd0, 8'h05, 4'h0, 1, 4'hA, 16);
    drain();

    test_name = "reset_mid";
    send(0, RDM, 2'd0, 8'h05, 4'h0, 0, 4'h0, 0);
    t = 0;
    while (!(cur == M2 && cm_ram[0]) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("found_io_m2", {31'd0, (cur == M2 && cm_ram[0])}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("sync_in_rst", {31'd0, sync}, 32'd1);
    check("ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    check("rsp_in_rst", {31'd0, rsp_valid}, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    snap = src_cnt;
    send(0, RDM, 2'd0, 8'h05, 4'h0, 1, 4'hA, 16);
    drain();
    check("src_reissued", src_cnt - snap, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
